// File: rtl/master_thread_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : master_thread_tracker
//  Brief    : Per-master outstanding-transaction table for the AXI4 crossbar.
//             Qualifies new address requests and tracks open counts per ID.
//  Revision : 1.0 - initial multi-thread release
// ============================================================================
module master_thread_tracker #(
  parameter int NUM_SLAVES       = 4,
  parameter int NUM_SLAVES_WIDTH = 2,
  parameter int MASTERID_WIDTH   = 4,
  parameter int NUM_THREADS      = 4,
  parameter int OPEN_TRANS_MAX   = 7,
  parameter int OPEN_TRANS_WIDTH = 3,
  parameter int STRICT_ORDER     = 0,
  parameter int NUM_THREADS_W    = $clog2(NUM_THREADS + 1)
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic                        reqValid,
  input  logic [MASTERID_WIDTH-1:0]   reqID,
  input  logic [NUM_SLAVES_WIDTH-1:0] reqSlaveID,
  input  logic [NUM_SLAVES-1:0]       stopTrans,
  output logic                        reqQual,
  input  logic                        openTransInc,
  input  logic                        openTransDec,
  input  logic [MASTERID_WIDTH-1:0]   currDataTransID,
  output logic [NUM_THREADS_W-1:0]    activeThreads,
  output logic                        idle,
  output logic                        protErr
);

  localparam logic [OPEN_TRANS_WIDTH-1:0] c_countOne = OPEN_TRANS_WIDTH'(1);
  localparam logic [OPEN_TRANS_WIDTH-1:0] c_countMax = OPEN_TRANS_WIDTH'(OPEN_TRANS_MAX);

  // Thread table
  logic [NUM_THREADS-1:0]        r_valid;
  logic [MASTERID_WIDTH-1:0]     r_entryId    [NUM_THREADS];
  logic [NUM_SLAVES_WIDTH-1:0]   r_entrySlave [NUM_THREADS];
  logic [OPEN_TRANS_WIDTH-1:0]   r_entryCount [NUM_THREADS];
  logic                          r_protErr;

  logic [NUM_THREADS-1:0]        w_nextValid;
  logic [MASTERID_WIDTH-1:0]     w_nextId    [NUM_THREADS];
  logic [NUM_SLAVES_WIDTH-1:0]   w_nextSlave [NUM_THREADS];
  logic [OPEN_TRANS_WIDTH-1:0]   w_nextCount [NUM_THREADS];

  logic [NUM_THREADS-1:0]        w_reqHit;
  logic [NUM_THREADS-1:0]        w_decHit;
  logic [NUM_THREADS-1:0]        w_slaveMismatch;
  logic [NUM_THREADS-1:0]        w_freeOneHot;
  logic [NUM_THREADS-1:0]        w_incSel;
  logic [NUM_THREADS-1:0]        w_decSel;
  logic                          w_hit;
  logic                          w_freeAvail;
  logic [NUM_SLAVES_WIDTH-1:0]   w_hitSlave;
  logic [OPEN_TRANS_WIDTH-1:0]   w_hitCount;
  logic                          w_condA;
  logic                          w_condB;
  logic                          w_doInc;
  logic                          w_doDec;
  logic                          w_incErr;
  logic                          w_decErr;
  logic [NUM_THREADS_W-1:0]      w_activeCount;

  always_comb begin
    w_hitSlave      = '0;
    w_hitCount      = '0;
    w_reqHit        = '0;
    w_decHit        = '0;
    w_slaveMismatch = '0;
    w_activeCount   = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_reqHit[i]        = r_valid[i] && (r_entryId[i] == reqID);
      w_decHit[i]        = r_valid[i] && (r_entryId[i] == currDataTransID);
      w_slaveMismatch[i] = r_valid[i] && (r_entrySlave[i] != reqSlaveID);
      w_activeCount      = w_activeCount + NUM_THREADS_W'(r_valid[i]);
      // IDs are unique in the table, so an OR-mux picks the single hit
      if (w_reqHit[i]) begin
        w_hitSlave = w_hitSlave | r_entrySlave[i];
        w_hitCount = w_hitCount | r_entryCount[i];
      end
    end
  end

  assign w_hit        = |w_reqHit;
  assign w_freeAvail  = ~&r_valid;
  assign w_freeOneHot = ~r_valid & (r_valid + NUM_THREADS'(1));

  assign w_condA = w_hit ? ((w_hitSlave == reqSlaveID) && (w_hitCount < c_countMax))
                         : w_freeAvail;

  generate
    if (STRICT_ORDER != 0) begin : g_strict
      // An idle table has no mismatching entries, so this also covers idle
      assign w_condB = ~|w_slaveMismatch;
    end else begin : g_relaxed
      assign w_condB = 1'b1;
    end
  endgenerate

  assign reqQual = reqValid && !stopTrans[reqSlaveID] && w_condA && w_condB;

  assign w_doInc  = openTransInc && reqQual;
  assign w_incErr = openTransInc && !reqQual;
  assign w_doDec  = openTransDec && (|w_decHit);
  assign w_decErr = openTransDec && !(|w_decHit);

  // Allocation uses the pre-edge free vector; a dec freeing an entry cannot feed it
  assign w_incSel = {NUM_THREADS{w_doInc}} & (w_hit ? w_reqHit : w_freeOneHot);
  assign w_decSel = {NUM_THREADS{w_doDec}} & w_decHit;

  always_comb begin
    w_nextValid = r_valid;
    for (int i = 0; i < NUM_THREADS; i++) begin
      w_nextId[i]    = r_entryId[i];
      w_nextSlave[i] = r_entrySlave[i];
      w_nextCount[i] = r_entryCount[i];
      if (w_incSel[i] && w_decSel[i]) begin
        w_nextCount[i] = r_entryCount[i];
      end else if (w_incSel[i]) begin
        if (r_valid[i]) begin
          w_nextCount[i] = r_entryCount[i] + c_countOne;
        end else begin
          w_nextValid[i] = 1'b1;
          w_nextId[i]    = reqID;
          w_nextSlave[i] = reqSlaveID;
          w_nextCount[i] = c_countOne;
        end
      end else if (w_decSel[i]) begin
        w_nextCount[i] = r_entryCount[i] - c_countOne;
        if (r_entryCount[i] == c_countOne) begin
          w_nextValid[i] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge sysClk or negedge sysReset) begin
    if (!sysReset) begin
      r_valid   <= '0;
      r_protErr <= 1'b0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_entryId[i]    <= '0;
        r_entrySlave[i] <= '0;
        r_entryCount[i] <= '0;
      end
    end else begin
      r_valid   <= w_nextValid;
      r_protErr <= w_incErr || w_decErr;
      for (int i = 0; i < NUM_THREADS; i++) begin
        r_entryId[i]    <= w_nextId[i];
        r_entrySlave[i] <= w_nextSlave[i];
        r_entryCount[i] <= w_nextCount[i];
      end
    end
  end

  assign activeThreads = w_activeCount;
  assign idle          = ~|r_valid;
  assign protErr       = r_protErr;

endmodule
`default_nettype wire

// File: tb/tb_master_thread_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_master_thread_tracker
//  Brief    : Directed self-checking bench for master_thread_tracker.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_master_thread_tracker;

  logic       sysClk;
  logic       sysReset;
  logic       reqValid, openTransInc, openTransDec;
  logic [3:0] reqID, currDataTransID, stopTrans;
  logic [1:0] reqSlaveID;
  logic       reqQual, idle, protErr;
  logic [2:0] activeThreads;

  logic       sReqValid, sOpenTransInc, sOpenTransDec;
  logic [3:0] sReqID, sCurrDataTransID, sStopTrans;
  logic [1:0] sReqSlaveID;
  logic       sReqQual, sIdle, sProtErr;
  logic [2:0] sActiveThreads;

  int tests = 0;
  int fails = 0;

  master_thread_tracker #(.STRICT_ORDER(0)) dut (
    .sysClk(sysClk), .sysReset(sysReset),
    .reqValid(reqValid), .reqID(reqID), .reqSlaveID(reqSlaveID),
    .stopTrans(stopTrans), .reqQual(reqQual),
    .openTransInc(openTransInc), .openTransDec(openTransDec),
    .currDataTransID(currDataTransID),
    .activeThreads(activeThreads), .idle(idle), .protErr(protErr)
  );

  master_thread_tracker #(.STRICT_ORDER(1)) dutS (
    .sysClk(sysClk), .sysReset(sysReset),
    .reqValid(sReqValid), .reqID(sReqID), .reqSlaveID(sReqSlaveID),
    .stopTrans(sStopTrans), .reqQual(sReqQual),
    .openTransInc(sOpenTransInc), .openTransDec(sOpenTransDec),
    .currDataTransID(sCurrDataTransID),
    .activeThreads(sActiveThreads), .idle(sIdle), .protErr(sProtErr)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic cyc();
    @(posedge sysClk);
    #1;
  endtask

  task automatic setReq(input logic v, input logic [3:0] id, input logic [1:0] slv);
    reqValid   = v;
    reqID      = id;
    reqSlaveID = slv;
  endtask

  initial begin
    sysReset = 1'b0;
    reqValid = 0; reqID = 0; reqSlaveID = 0; stopTrans = 0;
    openTransInc = 0; openTransDec = 0; currDataTransID = 0;
    sReqValid = 0; sReqID = 0; sReqSlaveID = 0; sStopTrans = 0;
    sOpenTransInc = 0; sOpenTransDec = 0; sCurrDataTransID = 0;

    cyc(); cyc();
    chk("rst_active", activeThreads, 0);
    chk("rst_idle",   idle, 1);
    chk("rst_qual",   reqQual, 0);
    chk("rst_prot",   protErr, 0);
    sysReset = 1'b1;
    cyc();

    // First allocation
    setReq(1, 3, 1); #1;
    chk("alloc_qual", reqQual, 1);
    chk("hit_onehot", $onehot0(dut.w_reqHit), 1);
    openTransInc = 1; cyc(); openTransInc = 0;
    chk("alloc_active", activeThreads, 1);
    chk("alloc_idle",   idle, 0);
    chk("alloc_id",     dut.r_entryId[0], 3);
    chk("alloc_slave",  dut.r_entrySlave[0], 1);
    chk("alloc_count",  dut.r_entryCount[0], 1);

    // Fill ID 3 to OPEN_TRANS_MAX
    openTransInc = 1;
    repeat (6) cyc();
    openTransInc = 0;
    chk("max_count", dut.r_entryCount[0], 7);
    chk("max_qual",  reqQual, 0);
    openTransInc = 1; cyc(); openTransInc = 0;
    chk("incerr_prot",   protErr, 1);
    chk("incerr_active", activeThreads, 1);
    chk("incerr_count",  dut.r_entryCount[0], 7);
    cyc();
    chk("incerr_pulse", protErr, 0);
    currDataTransID = 3; openTransDec = 1; cyc(); openTransDec = 0;
    chk("dec_requal", reqQual, 1);
    chk("dec_count",  dut.r_entryCount[0], 6);

    // Same ID to a different slave blocked until drained
    setReq(1, 3, 2); #1;
    chk("sameid_block", reqQual, 0);
    openTransDec = 1;
    repeat (6) cyc();
    openTransDec = 0;
    chk("drain_idle",   idle, 1);
    chk("drain_active", activeThreads, 0);
    chk("drain_qual",   reqQual, 1);
    chk("drain_prot",   protErr, 0);

    // Fill the table with IDs 1..4
    for (int id = 1; id <= 4; id++) begin
      setReq(1, 4'(id), 0);
      openTransInc = 1; cyc();
    end
    openTransInc = 0;
    chk("full_active", activeThreads, 4);
    setReq(1, 5, 0); #1;
    chk("full_qual", reqQual, 0);

    // Inc ID 1 while ID 2 frees
    setReq(1, 1, 0); #1;
    chk("hit_full_qual", reqQual, 1);
    openTransInc = 1; openTransDec = 1; currDataTransID = 2;
    cyc();
    openTransInc = 0; openTransDec = 0;
    chk("incdec_active", activeThreads, 3);
    chk("incdec_cnt1",   dut.r_entryCount[0], 2);
    chk("incdec_prot",   protErr, 0);
    setReq(1, 5, 0); #1;
    chk("realloc_qual", reqQual, 1);
    openTransInc = 1; cyc(); openTransInc = 0;
    chk("realloc_id",     dut.r_entryId[1], 5);
    chk("realloc_active", activeThreads, 4);

    // Inc and dec on the same entry at count 1
    openTransInc = 1; openTransDec = 1; currDataTransID = 5;
    cyc();
    openTransInc = 0; openTransDec = 0;
    chk("same_active", activeThreads, 4);
    chk("same_count",  dut.r_entryCount[1], 1);

    // Unknown-ID response
    currDataTransID = 9; openTransDec = 1; cyc(); openTransDec = 0;
    chk("decerr_prot",   protErr, 1);
    chk("decerr_active", activeThreads, 4);
    cyc();
    chk("decerr_pulse", protErr, 0);

    // Both errors on one edge
    setReq(1, 6, 0); #1;
    chk("both_qual", reqQual, 0);
    openTransInc = 1; openTransDec = 1; currDataTransID = 9;
    cyc();
    openTransInc = 0; openTransDec = 0;
    chk("both_prot",   protErr, 1);
    chk("both_active", activeThreads, 4);
    cyc();
    chk("both_pulse", protErr, 0);

    // Per-slave stop
    setReq(1, 1, 0); stopTrans = 4'b0001; #1;
    chk("stop_qual", reqQual, 0);
    stopTrans = 4'b0010; #1;
    chk("stop_other", reqQual, 1);
    stopTrans = 0;

    // Asynchronous reset mid-traffic
    #2 sysReset = 1'b0; #1;
    chk("midrst_idle",   idle, 1);
    chk("midrst_active", activeThreads, 0);
    cyc();
    sysReset = 1'b1;
    cyc();
    currDataTransID = 1; openTransDec = 1; cyc(); openTransDec = 0;
    chk("stale_prot", protErr, 1);

    // Strict versus relaxed ordering, ID 1 open on slave 0 in both
    setReq(1, 1, 0); sReqValid = 1; sReqID = 1; sReqSlaveID = 0;
    openTransInc = 1; sOpenTransInc = 1; cyc();
    openTransInc = 0; sOpenTransInc = 0;
    setReq(1, 2, 2); sReqID = 2; sReqSlaveID = 2; #1;
    chk("strict_block", sReqQual, 0);
    chk("relaxed_pass", reqQual, 1);
    sReqSlaveID = 0; #1;
    chk("strict_pass", sReqQual, 1);
    sStopTrans = 4'b0001; #1;
    chk("strict_stop", sReqQual, 0);
    chk("strict_prot", sProtErr, 0);
    sStopTrans = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/master_thread_tracker.md
Name: master_thread_tracker

Overview:
Per-master outstanding-transaction tracker for the AXI4 crossbar. Holds a table of NUM_THREADS thread entries, each with an ID, a target slave and an open count. Qualifies each new address request against AXI same-ID ordering, thread capacity, per-slave stop and an optional single-slave ordering mode. Counts are incremented on address acceptance and decremented on response completion. It is the multi-thread successor to the single-thread master dependence/transaction controller pair.

Parameters:
NUM_SLAVES, 4, slave count including the internal DERR slave
NUM_SLAVES_WIDTH, 2, bits to encode a slave number
MASTERID_WIDTH, 4, infrastructure ID plus requestor ID width
NUM_THREADS, 4, number of table entries (1..16)
OPEN_TRANS_MAX, 7, max outstanding transactions per thread
OPEN_TRANS_WIDTH, 3, count width; must hold OPEN_TRANS_MAX
STRICT_ORDER, 0, 1 = all open threads of this master must target a single slave

Ports:
sysClk  in  1  clock
sysReset  in  1  asynchronous active-low reset
reqValid  in  1  master has a decoded request
reqID  in  MASTERID_WIDTH  ID of the request
reqSlaveID  in  NUM_SLAVES_WIDTH  decoded target slave
stopTrans  in  NUM_SLAVES  per-slave stop from the write FIFOs
reqQual  out  1  request may be granted (combinational)
openTransInc  in  1  request accepted this cycle
openTransDec  in  1  a transaction completed this cycle
currDataTransID  in  MASTERID_WIDTH  ID of the completed transaction
activeThreads  out  NUM_THREADS_W  number of valid entries (width clog2(NUM_THREADS+1))
idle  out  1  no valid entries
protErr  out  1  registered one-cycle pulse on a protocol violation

Behaviour:
- Reset (sysReset=0, asynchronous): all entries invalid, counts 0, protErr=0. Result: activeThreads=0, idle=1, reqQual=0.
- hit = any valid entry with id==reqID. At most one entry may hit, which the bench checks as an invariant. freeAvail = any invalid entry.
- reqQual = reqValid & !stopTrans[reqSlaveID] & A & B:
  - A: on a hit, entry.slave==reqSlaveID and entry.count<OPEN_TRANS_MAX. On a miss, freeAvail.
  - B: if STRICT_ORDER=1, either idle, or every valid entry's slave==reqSlaveID. If STRICT_ORDER=0, B=1.
  - Same ID to a different slave is blocked until that ID fully drains.
- reqQual is purely combinational from table state and inputs. Zero latency.
- openTransInc is applied at the clock edge only when reqQual=1:
  - On a hit, count+1.
  - On a miss, allocate the lowest-index invalid entry: valid=1, id=reqID, slave=reqSlaveID, count=1.
- openTransInc with reqQual=0: table unchanged, protErr pulses next cycle.
- openTransDec: the entry matching currDataTransID decrements its count. If the result is 0, valid=0 in the same edge and the entry is freed.
- openTransDec with no matching valid entry: table unchanged, protErr pulses.
- Simultaneous inc and dec on the same entry: count unchanged, entry stays valid. This holds even when count==1.
- Simultaneous inc-miss and a dec that frees a different entry: allocation uses the pre-edge free vector. If the table was full, reqQual was already 0, so no allocation happens that cycle.
- Count saturation cannot occur because reqQual gates the increment at OPEN_TRANS_MAX. Count never underflows because count==0 implies invalid.
- activeThreads and idle are combinational from the registered valid bits and update the cycle after the inc/dec edge.
- protErr is high for exactly one cycle per offending edge, including when both errors occur together.
- Reset mid-operation clears the whole table immediately. Responses for pre-reset transactions are then reported as protErr.

Test Plan:
- Post-reset, reqValid=1, reqID=3, slave=1 -> reqQual=1. After inc: activeThreads=1, idle=0, entry0={3,1,1}.
- ID 3 to slave 1, seven incs with OPEN_TRANS_MAX=7 -> reqQual=0 on the 8th request. One dec of ID 3 -> reqQual=1 next cycle.
- ID 3 open on slave 1, request ID 3 to slave 2 -> reqQual=0. Drain ID 3 to 0 -> entry freed, idle=1, reqQual=1 for slave 2.
- NUM_THREADS=4, open IDs 1,2,3,4 -> request ID 5 gives reqQual=0. In one cycle, inc ID 1 and dec ID 2 (count 1) -> ID 2 freed, no allocation. Next cycle ID 5 qualifies and occupies entry 1.
- STRICT_ORDER=1, ID 1 open on slave 0, request ID 2 to slave 2 -> reqQual=0. Same request to slave 0 -> reqQual=1. With stopTrans[0]=1 -> reqQual=0.
- Dec of unknown ID 9 -> protErr=1 for one cycle, table unchanged. Inc while reqQual=0 -> protErr pulse, activeThreads unchanged. Reset asserted mid-traffic -> idle=1 immediately.
